// File: rtl/mux_pkg.sv
// Shared types and constants for the N_CH:1 channel multiplexer family.
package mux_pkg;

    typedef enum logic {
        S_DIRECT = 1'b0,
        S_SCAN   = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nch_comb.sv
// Pure combinational N_CH:1 W-bit selector; out-of-range select returns 0 and raises err.
// Latency: 0 cycles. Backpressure: none (no state).
module mux_nch_comb #(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int SEL_W = 4
) (
    input  logic [N_CH*W-1:0] chans,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      data,
    output logic              err
);

    always_comb begin
        data = '0;
        err  = (int'(sel) >= N_CH);
        for (int k = 0; k < N_CH; k++) begin
            if (int'(sel) == k) begin
                data = chans[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_nch_scan.sv
// Registered N_CH:1 mux with DIRECT (external select) and SCAN (round-robin, DWELL transfers per channel).
// Latency: 1 cycle. Backpressure: out_valid & !out_ready freezes outputs, pointer, dwell count and state.
module mux_nch_scan
    import mux_pkg::*;
#(
    parameter int  N_CH  = 16,
    parameter int  W     = 1,
    parameter int  DWELL = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt, mux_sel;
    logic [DCNT_W-1:0]  dwell_cnt, dwell_nxt;
    logic [W-1:0]       mux_data;
    logic               mux_err;
    logic               load;

    assign load = !out_valid || out_ready;

    // Next values assume a load. Once in SCAN out_valid is always 1, so a load
    // there is also a handshake; the captured sample uses the advanced pointer.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        dwell_nxt = dwell_cnt;
        mux_sel   = sel;
        if (mode == MODE_SCAN) begin
            state_nxt = S_SCAN;
            if (state == S_DIRECT) begin
                ptr_nxt   = '0;
                dwell_nxt = '0;
            end else if (dwell_cnt == DCNT_W'(DWELL - 1)) begin
                dwell_nxt = '0;
                ptr_nxt   = (ptr == SEL_W'(N_CH - 1)) ? '0 : ptr + 1'b1;
            end else begin
                dwell_nxt = dwell_cnt + 1'b1;
            end
            mux_sel = ptr_nxt;
        end else begin
            state_nxt = S_DIRECT;
        end
    end

    mux_nch_comb #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_comb (
        .chans (in),
        .sel   (mux_sel),
        .data  (mux_data),
        .err   (mux_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_DIRECT;
            ptr       <= '0;
            dwell_cnt <= '0;
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            dwell_cnt <= dwell_nxt;
            out_data  <= mux_data;
            out_sel   <= mux_sel;
            out_err   <= mux_err;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_nch_scan.sv
// Directed bench: three mux_nch_scan configurations (16x1 dwell 1, 16x1 dwell 3, 10x4 dwell 1).
module tb_mux_nch_scan;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] in16;
    logic        mode16;
    logic [3:0]  sel16;
    logic        rdy16;
    logic        a_data, b_data;
    logic [3:0]  a_sel, b_sel;
    logic        a_err, b_err, a_vld, b_vld;

    logic [39:0] in10;
    logic        mode10;
    logic [3:0]  sel10;
    logic        rdy10;
    logic [3:0]  c_data;
    logic [3:0]  c_sel;
    logic        c_err, c_vld;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] sel;
        logic       rdy;
        logic [3:0] exp_data;
        logic [3:0] exp_sel;
        logic       exp_err;
    } vec_t;

    vec_t vt1 [16];
    vec_t vt10 [7];

    always #5 clk = ~clk;

    mux_nch_scan #(.N_CH(16), .W(1), .DWELL(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in(in16), .mode(mode16), .sel(sel16),
        .out_data(a_data), .out_sel(a_sel), .out_err(a_err), .out_valid(a_vld), .out_ready(rdy16)
    );

    mux_nch_scan #(.N_CH(16), .W(1), .DWELL(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in(in16), .mode(mode16), .sel(sel16),
        .out_data(b_data), .out_sel(b_sel), .out_err(b_err), .out_valid(b_vld), .out_ready(rdy16)
    );

    mux_nch_scan #(.N_CH(10), .W(4), .DWELL(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in(in10), .mode(mode10), .sel(sel10),
        .out_data(c_data), .out_sel(c_sel), .out_err(c_err), .out_valid(c_vld), .out_ready(rdy10)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int s, input logic d, input logic e, input logic v);
        chk({tag, " a.sel"}, 32'(a_sel), 32'(s));
        chk({tag, " a.data"}, 32'(a_data), 32'(d));
        chk({tag, " a.err"}, 32'(a_err), 32'(e));
        chk({tag, " a.valid"}, 32'(a_vld), 32'(v));
    endtask

    task automatic chk_b(input string tag, input int s, input logic d, input logic v);
        chk({tag, " b.sel"}, 32'(b_sel), 32'(s));
        chk({tag, " b.data"}, 32'(b_data), 32'(d));
        chk({tag, " b.err"}, 32'(b_err), 32'(0));
        chk({tag, " b.valid"}, 32'(b_vld), 32'(v));
    endtask

    task automatic chk_c(input string tag, input logic [3:0] s, input logic [3:0] d, input logic e, input logic v);
        chk({tag, " c.sel"}, 32'(c_sel), 32'(s));
        chk({tag, " c.data"}, 32'(c_data), 32'(d));
        chk({tag, " c.err"}, 32'(c_err), 32'(e));
        chk({tag, " c.valid"}, 32'(c_vld), 32'(v));
    endtask

    initial begin
        // 16'hAAAA: odd channels are 1, even channels are 0
        for (int k = 0; k < 16; k++) begin
            vt1[k] = '{sel: 4'(k), rdy: 1'b1, exp_data: 4'(k % 2), exp_sel: 4'(k), exp_err: 1'b0};
        end
        // channel k of in10 holds the value k, so ch9 = in[39:36] = 9
        vt10[0] = '{sel: 4'd12, rdy: 1'b1, exp_data: 4'd0, exp_sel: 4'd12, exp_err: 1'b1};
        vt10[1] = '{sel: 4'd9,  rdy: 1'b1, exp_data: 4'd9, exp_sel: 4'd9,  exp_err: 1'b0};
        vt10[2] = '{sel: 4'd0,  rdy: 1'b1, exp_data: 4'd0, exp_sel: 4'd0,  exp_err: 1'b0};
        vt10[3] = '{sel: 4'd5,  rdy: 1'b1, exp_data: 4'd5, exp_sel: 4'd5,  exp_err: 1'b0};
        vt10[4] = '{sel: 4'd15, rdy: 1'b1, exp_data: 4'd0, exp_sel: 4'd15, exp_err: 1'b1};
        vt10[5] = '{sel: 4'd3,  rdy: 1'b0, exp_data: 4'd0, exp_sel: 4'd15, exp_err: 1'b1};
        vt10[6] = '{sel: 4'd7,  rdy: 1'b1, exp_data: 4'd7, exp_sel: 4'd7,  exp_err: 1'b0};

        rst_n  = 1'b0;
        in16   = 16'hAAAA;
        mode16 = 1'b0;
        sel16  = 4'd0;
        rdy16  = 1'b1;
        in10   = 40'h9876543210;
        mode10 = 1'b0;
        sel10  = 4'd0;
        rdy10  = 1'b1;

        #1;
        chk_a("reset", 0, 1'b0, 1'b0, 1'b0);
        chk_b("reset", 0, 1'b0, 1'b0);
        chk_c("reset", 4'd0, 4'd0, 1'b0, 1'b0);
        #11 rst_n = 1'b1;

        // 10x4 DIRECT, including out-of-range select and a one-cycle stall
        for (int i = 0; i < 7; i++) begin
            sel10 = vt10[i].sel;
            rdy10 = vt10[i].rdy;
            step();
            chk_c($sformatf("dir10[%0d]", i), vt10[i].exp_sel, vt10[i].exp_data, vt10[i].exp_err, 1'b1);
        end

        // 16x1 DIRECT sweep over all selects
        for (int i = 0; i < 16; i++) begin
            sel16 = vt1[i].sel;
            rdy16 = vt1[i].rdy;
            step();
            chk_a($sformatf("dir16[%0d]", i), int'(vt1[i].exp_sel), vt1[i].exp_data[0], vt1[i].exp_err, 1'b1);
        end

        // SCAN: entry captures ch0; dwell 1 wraps every 16, dwell 3 every 48
        mode16 = 1'b1;
        for (int i = 0; i <= 55; i++) begin
            step();
            chk_a($sformatf("scan[%0d]", i), i % 16, 1'((i % 16) % 2), 1'b0, 1'b1);
            chk_b($sformatf("scan3[%0d]", i), (i / 3) % 16, 1'(((i / 3) % 16) % 2), 1'b1);
        end

        // stall at ptr 7 while in/sel toggle
        rdy16 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            in16  = 16'h5555 ^ 16'(j * 16'h1111);
            sel16 = 4'(j + 2);
            step();
            chk_a($sformatf("stall[%0d]", j), 7, 1'b1, 1'b0, 1'b1);
            chk_b($sformatf("stall3[%0d]", j), 2, 1'b0, 1'b1);
        end
        in16  = 16'hAAAA;
        rdy16 = 1'b1;
        step();
        chk_a("resume0", 8, 1'b0, 1'b0, 1'b1);
        chk_b("resume0", 2, 1'b0, 1'b1);
        step();
        chk_a("resume1", 9, 1'b1, 1'b0, 1'b1);
        chk_b("resume1", 3, 1'b1, 1'b1);

        // mode toggles: leave SCAN on a load, then re-enter with ptr reset
        mode16 = 1'b0;
        sel16  = 4'd3;
        step();
        chk_a("to_direct", 3, 1'b1, 1'b0, 1'b1);
        chk_b("to_direct", 3, 1'b1, 1'b1);
        mode16 = 1'b1;
        step();
        chk_a("to_scan", 0, 1'b0, 1'b0, 1'b1);
        chk_b("to_scan", 0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) step();
        chk_a("pre_rst", 5, 1'b1, 1'b0, 1'b1);

        // asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk_a("async_rst", 0, 1'b0, 1'b0, 1'b0);
        chk_b("async_rst", 0, 1'b0, 1'b0);
        chk_c("async_rst", 4'd0, 4'd0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        #1;
        chk_a("rst_released", 0, 1'b0, 1'b0, 1'b0);
        step();
        chk_a("restart0", 0, 1'b0, 1'b0, 1'b1);
        step();
        chk_a("restart1", 1, 1'b1, 1'b0, 1'b1);
        chk_b("restart1", 0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
